// File: rtl/pcint_pkg.sv
// Shared constants for the pin-change interrupt controller: group geometry and default bus addresses.
package pcint_pkg;

    localparam int MAX_GRP = 4;
    localparam int GRP_W   = 8;

    localparam logic [5:0] PCIFR_ADDR_DFLT  = 6'h1B;
    localparam logic [7:0] PCICR_ADDR_DFLT  = 8'h68;
    localparam logic [7:0] PCMSK0_ADDR_DFLT = 8'h6B;

    // PCMSKn registers sit at consecutive data-space addresses starting at PCMSK0.
    function automatic logic [7:0] mskAddr(input logic [7:0] base, input int n);
        return base + 8'(n);
    endfunction

endpackage

// File: rtl/pcint_group.sv
// One 8-pin group: holds PCMSKn and the previous level, reports a masked pin change.
// Build option PCINT_FILTER_EN inserts a 2-sample agreement filter in front of the edge detector.
module pcint_group
    import pcint_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             primed_i,
    input  logic [GRP_W-1:0] pins_i,
    input  logic             mask_we_i,
    input  logic [GRP_W-1:0] mask_wdata_i,
    output logic [GRP_W-1:0] mask_o,
    output logic             chg_o
);

    logic [GRP_W-1:0] mask_q, mask_d;
    logic [GRP_W-1:0] prev_q, prev_d;
    logic [GRP_W-1:0] level;

`ifdef PCINT_FILTER_EN
    logic [GRP_W-1:0] samp_q;
    logic [GRP_W-1:0] agree;

    // A pin's filtered level only moves once two consecutive raw samples agree; prev_q holds that level.
    assign agree = ~(pins_i ^ samp_q);
    assign level = (pins_i & agree) | (prev_q & ~agree);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            samp_q <= '0;
        end else begin
            samp_q <= pins_i;
        end
    end
`else
    assign level = pins_i;
`endif

    assign prev_d = primed_i ? level : pins_i;
    assign mask_d = mask_we_i ? mask_wdata_i : mask_q;
    assign chg_o  = primed_i & (|((level ^ prev_q) & mask_q));
    assign mask_o = mask_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q <= '0;
            prev_q <= '0;
        end else begin
            mask_q <= mask_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/pcint_ctrl.sv
// Pin-change interrupt controller top: PCICR/PCIFR, bus decode, read mux and one pcint_group per 8 pins.
// Build option PCINT_FILTER_EN (handled inside pcint_group) adds a 2-sample glitch filter per pin.
module pcint_ctrl
    import pcint_pkg::*;
#(
    parameter int         N_GRP       = 4,
    parameter logic [5:0] PCIFR_ADDR  = PCIFR_ADDR_DFLT,
    parameter logic [7:0] PCICR_ADDR  = PCICR_ADDR_DFLT,
    parameter logic [7:0] PCMSK0_ADDR = PCMSK0_ADDR_DFLT
) (
    input  logic                   cp2,
    input  logic                   ireset,
    input  logic [5:0]             IO_Addr,
    input  logic                   iore,
    input  logic                   iowe,
    input  logic [7:0]             ramadr,
    input  logic                   ramre,
    input  logic                   ramwe,
    input  logic [7:0]             dbus_in,
    output logic [7:0]             dbus_out,
    output logic                   out_en,
    input  logic [GRP_W*N_GRP-1:0] pin_sync,
    output logic [N_GRP-1:0]       irq,
    input  logic [N_GRP-1:0]       irq_ack
);

    logic                   primed_q;
    logic [N_GRP-1:0]       pcicr_q, pcicr_d;
    logic [N_GRP-1:0]       pcifr_q, pcifr_d;
    logic [N_GRP-1:0]       chg;
    logic [N_GRP-1:0]       mskWe;
    logic [GRP_W-1:0]       mskVal [N_GRP];
    logic                   pcifrWr, pcicrWr;

    assign pcifrWr = iowe && (IO_Addr == PCIFR_ADDR);
    assign pcicrWr = ramwe && (ramadr == PCICR_ADDR);

    for (genvar g = 0; g < N_GRP; g++) begin : gGrp
        assign mskWe[g] = ramwe && (ramadr == mskAddr(PCMSK0_ADDR, g));

        pcint_group uGrp (
            .clk_i        (cp2),
            .rst_ni       (ireset),
            .primed_i     (primed_q),
            .pins_i       (pin_sync[GRP_W*g +: GRP_W]),
            .mask_we_i    (mskWe[g]),
            .mask_wdata_i (dbus_in),
            .mask_o       (mskVal[g]),
            .chg_o        (chg[g])
        );
    end

    // Clears (write-1 or vector ack) apply first so a coincident pin change still leaves the flag set.
    always_comb begin
        pcicr_d = pcicr_q;
        if (pcicrWr) begin
            pcicr_d = dbus_in[N_GRP-1:0];
        end
        pcifr_d = pcifr_q;
        if (pcifrWr) begin
            pcifr_d = pcifr_d & ~dbus_in[N_GRP-1:0];
        end
        pcifr_d = (pcifr_d & ~irq_ack) | chg;
    end

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            primed_q <= 1'b0;
            pcicr_q  <= '0;
            pcifr_q  <= '0;
        end else begin
            primed_q <= 1'b1;
            pcicr_q  <= pcicr_d;
            pcifr_q  <= pcifr_d;
        end
    end

    assign irq = pcifr_q & pcicr_q;

    always_comb begin
        dbus_out = '0;
        out_en   = 1'b0;
        if (ireset) begin
            if (iore && (IO_Addr == PCIFR_ADDR)) begin
                out_en   = 1'b1;
                dbus_out = dbus_out | 8'(pcifr_q);
            end
            if (ramre) begin
                if (ramadr == PCICR_ADDR) begin
                    out_en   = 1'b1;
                    dbus_out = dbus_out | 8'(pcicr_q);
                end
                for (int n = 0; n < N_GRP; n++) begin
                    if (ramadr == mskAddr(PCMSK0_ADDR, n)) begin
                        out_en   = 1'b1;
                        dbus_out = dbus_out | mskVal[n];
                    end
                end
            end
        end
    end

endmodule
